// File: rtl/pixel_stream_pkg.sv
// Shared pixel-stream definitions: FSM state encoding and default frame geometry.
// Used by pixel_frame_reader (optional PIXEL_SRC_BACKPRESSURE_EN) and image_processor.
package pixel_stream_pkg;

    localparam int DEFAULT_PIXEL_W      = 24;
    localparam int DEFAULT_IMAGE_WIDTH  = 512;
    localparam int DEFAULT_IMAGE_HEIGHT = 512;
    localparam int GAP_W                = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_EMIT,
        ST_GAP,
        ST_DONE
    } pix_state_t;

    // Counter width that stays legal for a dimension of 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_xy_counter.sv
// Raster x/y and linear address counters; the address wraps to 0 after the last pixel.
module pixel_xy_counter
    import pixel_stream_pkg::*;
#(
    parameter int IMAGE_WIDTH  = DEFAULT_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEFAULT_IMAGE_HEIGHT,
    parameter int ADDR_W       = 18
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last_in_line,
    output logic              o_last_in_frame,
    output logic              o_first_in_frame
);

    localparam int X_W = cnt_width(IMAGE_WIDTH);
    localparam int Y_W = cnt_width(IMAGE_HEIGHT);
    localparam logic [X_W-1:0] X_LAST = X_W'(IMAGE_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMAGE_HEIGHT - 1);

    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [ADDR_W-1:0] r_addr;
    logic              w_last_x;
    logic              w_last_y;

    assign w_last_x         = (r_x == X_LAST);
    assign w_last_y         = (r_y == Y_LAST);
    assign o_addr           = r_addr;
    assign o_last_in_line   = w_last_x;
    assign o_last_in_frame  = w_last_x & w_last_y;
    assign o_first_in_frame = (r_x == '0) & (r_y == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (i_clear) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (i_advance) begin
            if (w_last_x) begin
                r_x <= '0;
                r_y <= w_last_y ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
            r_addr <= (w_last_x && w_last_y) ? '0 : r_addr + 1'b1;
        end
    end

endmodule

// File: rtl/pixel_frame_reader.sv
// Streams a stored RGB frame from a 1-cycle-latency RAM in raster order with sof/eol/eof markers.
// Define PIXEL_SRC_BACKPRESSURE_EN to add i_pixel_ready_in and hold each pixel until accepted.
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | RAM read strobe at current address
//   WAIT  | RAM data captured into pixel register
//   EMIT  | pixel valid, advance on acceptance
//   GAP   | latched inter-pixel idle cycles
//   DONE  | one-cycle done pulse
module pixel_frame_reader
    import pixel_stream_pkg::*;
#(
    parameter int IMAGE_WIDTH  = DEFAULT_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEFAULT_IMAGE_HEIGHT,
    parameter int PIXEL_W      = DEFAULT_PIXEL_W,
    parameter int ADDR_W       = 18
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [GAP_W-1:0]   i_gap_cycles,
    output logic               o_mem_rd_en,
    output logic [ADDR_W-1:0]  o_mem_addr,
    input  logic [PIXEL_W-1:0] i_mem_rdata,
`ifdef PIXEL_SRC_BACKPRESSURE_EN
    input  logic               i_pixel_ready_in,
`endif
    output logic               o_pixel_valid_out,
    output logic [PIXEL_W-1:0] o_pixel_out,
    output logic               o_sof_out,
    output logic               o_eol_out,
    output logic               o_eof_out,
    output logic               o_busy,
    output logic               o_done
);

    pix_state_t       r_state;
    pix_state_t       w_next;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             w_ready;
    logic             w_accept;
    logic             w_clear;
    logic             w_last_in_line;
    logic             w_last_in_frame;
    logic             w_first_in_frame;
    logic             w_rd_en;
    logic             w_valid;
    logic             w_busy;
    logic             w_done;

`ifdef PIXEL_SRC_BACKPRESSURE_EN
    assign w_ready = i_pixel_ready_in;
`else
    assign w_ready = 1'b1;
`endif

    assign w_accept = (r_state == ST_EMIT) & w_ready;
    assign w_clear  = (r_state == ST_IDLE) & i_start & ~i_abort;

    pixel_xy_counter #(
        .IMAGE_WIDTH (IMAGE_WIDTH),
        .IMAGE_HEIGHT(IMAGE_HEIGHT),
        .ADDR_W      (ADDR_W)
    ) u_xy (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_clear         (w_clear),
        .i_advance       (w_accept),
        .o_addr          (o_mem_addr),
        .o_last_in_line  (w_last_in_line),
        .o_last_in_frame (w_last_in_frame),
        .o_first_in_frame(w_first_in_frame)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_gap     <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_clear)
                r_gap <= i_gap_cycles;
            if (r_state == ST_EMIT && w_next == ST_GAP)
                r_gap_cnt <= r_gap - 1'b1;
            else if (r_state == ST_GAP && r_gap_cnt != '0)
                r_gap_cnt <= r_gap_cnt - 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        if (i_abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (i_start) w_next = ST_FETCH;
                ST_FETCH: w_next = ST_WAIT;
                ST_WAIT:  w_next = ST_EMIT;
                ST_EMIT: begin
                    if (w_accept) begin
                        if (w_last_in_frame) w_next = ST_DONE;
                        else if (r_gap != '0) w_next = ST_GAP;
                        else                  w_next = ST_FETCH;
                    end
                end
                ST_GAP:   if (r_gap_cnt == '0) w_next = ST_FETCH;
                ST_DONE:  w_next = ST_IDLE;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with it once registered.
    always_comb begin
        w_rd_en = (w_next == ST_FETCH);
        w_valid = (w_next == ST_EMIT);
        w_busy  = (w_next inside {ST_FETCH, ST_WAIT, ST_EMIT, ST_GAP});
        w_done  = (w_next == ST_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mem_rd_en       <= 1'b0;
            o_pixel_valid_out <= 1'b0;
            o_pixel_out       <= '0;
            o_sof_out         <= 1'b0;
            o_eol_out         <= 1'b0;
            o_eof_out         <= 1'b0;
            o_busy            <= 1'b0;
            o_done            <= 1'b0;
        end else begin
            o_mem_rd_en       <= w_rd_en;
            o_pixel_valid_out <= w_valid;
            o_busy            <= w_busy;
            o_done            <= w_done;
            if (w_valid) begin
                if (r_state == ST_WAIT) begin
                    o_pixel_out <= i_mem_rdata;
                    o_sof_out   <= w_first_in_frame;
                    o_eol_out   <= w_last_in_line;
                    o_eof_out   <= w_last_in_frame;
                end
            end else begin
                o_sof_out <= 1'b0;
                o_eol_out <= 1'b0;
                o_eof_out <= 1'b0;
            end
        end
    end

endmodule
